// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller for the 5-stage MIPS core: detects D-stage data hazards against E/M,
// runs the mult/div busy timer and keeps profiling counters of stall cycles.
module hazard_stall_unit #(
   parameter int unsigned MULT_CYCLES  = 5,
   parameter int unsigned DIV_CYCLES   = 10,
   parameter int unsigned CHECK_LOAD_M = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ir_d,
   input  logic [31:0]      ir_e,
   input  logic [31:0]      ir_m,
   output logic             pc_en,
   output logic             d_en,
   output logic             e_clr,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] md_stall_cnt
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t     state;
   logic [CW-1:0] cnt;

   // Destination register of an instruction; 0 means it writes nothing we care about.
   function automatic logic [4:0] wr_reg(input logic [31:0] ir);
      logic [4:0] w;
      w = 5'd0;
      if (ir[31:26] == 6'h00) begin
         if (!(ir[5:0] inside {6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}))
            w = ir[15:11];
      end else if (ir[31:26] == 6'h03) begin
         w = 5'd31;
      end else if (ir[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, [6'h08:6'h0F]}) begin
         w = ir[20:16];
      end
      return w;
   endfunction

   function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] w);
      logic uses_rs;
      logic uses_rt;
      uses_rs = !((ir[31:26] inside {6'h02, 6'h03, 6'h0F}) ||
                  (ir[31:26] == 6'h00 && ir[5:0] inside {6'h10, 6'h12}));
      uses_rt = (ir[31:26] == 6'h00 && !(ir[5:0] inside {[6'h08:6'h09], [6'h10:6'h13]})) ||
                (ir[31:26] == 6'h1C && ir[5:0] == 6'h04) ||
                (ir[31:26] inside {6'h04, 6'h05, 6'h28, 6'h29, 6'h2B});
      return (w != 5'd0) && ((uses_rs && ir[25:21] == w) || (uses_rt && ir[20:16] == w));
   endfunction

   function automatic logic is_load(input logic [31:0] ir);
      return ir[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
   endfunction

   function automatic logic is_ctrl(input logic [31:0] ir);
      return (ir[31:26] inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) ||
             (ir[31:26] == 6'h00 && ir[5:0] inside {6'h08, 6'h09});
   endfunction

   function automatic logic is_mult(input logic [31:0] ir);
      return (ir[31:26] == 6'h00 && ir[5:0] inside {6'h18, 6'h19}) ||
             (ir[31:26] == 6'h1C && ir[5:0] == 6'h04);
   endfunction

   function automatic logic is_div(input logic [31:0] ir);
      return ir[31:26] == 6'h00 && ir[5:0] inside {6'h1A, 6'h1B};
   endfunction

   function automatic logic is_md_use(input logic [31:0] ir);
      return is_mult(ir) || is_div(ir) ||
             (ir[31:26] == 6'h00 && ir[5:0] inside {[6'h10:6'h13]});
   endfunction

   logic [4:0] wr_e;
   logic [4:0] wr_m;
   logic       hz_ctrl_e;
   logic       hz_ctrl_m;
   logic       hz_load_e;
   logic       hz_md;
   logic       stall;
   logic       md_only;

   assign wr_e      = wr_reg(ir_e);
   assign wr_m      = wr_reg(ir_m);
   assign hz_ctrl_e = is_ctrl(ir_d) && reads_reg(ir_d, wr_e);
   assign hz_ctrl_m = (CHECK_LOAD_M != 0) && is_ctrl(ir_d) && is_load(ir_m) && reads_reg(ir_d, wr_m);
   assign hz_load_e = is_load(ir_e) && reads_reg(ir_d, wr_e);
   assign hz_md     = md_busy && is_md_use(ir_d);
   assign stall     = hz_ctrl_e || hz_ctrl_m || hz_load_e || hz_md;
   assign md_only   = hz_md && !(hz_ctrl_e || hz_ctrl_m || hz_load_e);

   assign pc_en   = !stall;
   assign d_en    = !stall;
   assign e_clr   = stall;
   // Busy already in the cycle the op enters E, so a dependent op in D is held that same cycle.
   assign md_busy = (state == BUSY) || (is_mult(ir_e) || is_div(ir_e));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_mult(ir_e)) begin
                  cnt   <= MULT_LOAD;
                  state <= (MULT_LOAD != '0) ? BUSY : IDLE;
               end else if (is_div(ir_e)) begin
                  cnt   <= DIV_LOAD;
                  state <= (DIV_LOAD != '0) ? BUSY : IDLE;
               end
            end
            BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt    <= '0;
         md_stall_cnt <= '0;
      end else begin
         if (stall)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (md_only)
            md_stall_cnt <= md_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (default and short-mult/no-M-check/4-bit counters)
// against a cycle-level model of the hazard rules and the mult/div busy window.
module tb_hazard_stall_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] irD, irE, irM;
   logic        pcEn[2], dEn[2], eClr[2], mdBusy[2];
   logic [31:0] stallCnt0, mdStallCnt0;
   logic [3:0]  stallCnt1, mdStallCnt1;
   logic [31:0] stallObs[2], mdStallObs[2];

   int checkCount = 0;
   int failCount  = 0;
   int cycle;
   int mdEnd[2];
   int stallTotal[2];
   int mdStallTotal[2];
   bit expStall[2];
   bit expMdOnly[2];

   always #5 clock = ~clock;

   assign stallObs[0]   = stallCnt0;
   assign stallObs[1]   = {28'd0, stallCnt1};
   assign mdStallObs[0] = mdStallCnt0;
   assign mdStallObs[1] = {28'd0, mdStallCnt1};

   hazard_stall_unit u0 (
      .clk(clock), .reset(reset), .ir_d(irD), .ir_e(irE), .ir_m(irM),
      .pc_en(pcEn[0]), .d_en(dEn[0]), .e_clr(eClr[0]), .md_busy(mdBusy[0]),
      .stall_cnt(stallCnt0), .md_stall_cnt(mdStallCnt0)
   );

   hazard_stall_unit #(.MULT_CYCLES(1), .DIV_CYCLES(10), .CHECK_LOAD_M(0), .CNT_W(4)) u1 (
      .clk(clock), .reset(reset), .ir_d(irD), .ir_e(irE), .ir_m(irM),
      .pc_en(pcEn[1]), .d_en(dEn[1]), .e_clr(eClr[1]), .md_busy(mdBusy[1]),
      .stall_cnt(stallCnt1), .md_stall_cnt(mdStallCnt1)
   );

   function automatic logic [31:0] rType(int rs, int rt, int rd, logic [5:0] fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] iType(logic [5:0] op, int rs, int rt);
      return {op, 5'(rs), 5'(rt), 16'h0004};
   endfunction

   function automatic int writeReg(logic [31:0] ir);
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      if (op == 6'h00 && !(fn inside {6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}))
         return int'(ir[15:11]);
      if (op == 6'h03)
         return 31;
      if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, [6'h08:6'h0F]})
         return int'(ir[20:16]);
      return 0;
   endfunction

   function automatic bit readsReg(logic [31:0] ir, int w);
      logic [5:0] op;
      logic [5:0] fn;
      bit usesRs, usesRt;
      op = ir[31:26];
      fn = ir[5:0];
      usesRs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F || (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)));
      usesRt = (op == 6'h00 && !(fn inside {6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13})) ||
               (op == 6'h1C && fn == 6'h04) || (op inside {6'h04, 6'h05, 6'h28, 6'h29, 6'h2B});
      if (w == 0)
         return 1'b0;
      return (usesRs && int'(ir[25:21]) == w) || (usesRt && int'(ir[20:16]) == w);
   endfunction

   function automatic bit isLoad(logic [31:0] ir);
      return ir[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
   endfunction

   function automatic bit isCtrl(logic [31:0] ir);
      return (ir[31:26] inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) ||
             (ir[31:26] == 6'h00 && (ir[5:0] == 6'h08 || ir[5:0] == 6'h09));
   endfunction

   // 0: not a timer op, 1: mult family, 2: div family.
   function automatic int mdClass(logic [31:0] ir);
      if ((ir[31:26] == 6'h00 && (ir[5:0] == 6'h18 || ir[5:0] == 6'h19)) ||
          (ir[31:26] == 6'h1C && ir[5:0] == 6'h04))
         return 1;
      if (ir[31:26] == 6'h00 && (ir[5:0] == 6'h1A || ir[5:0] == 6'h1B))
         return 2;
      return 0;
   endfunction

   function automatic bit isMdUse(logic [31:0] ir);
      return mdClass(ir) != 0 || (ir[31:26] == 6'h00 && ir[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13});
   endfunction

   function automatic int mdLatency(int inst, int cls);
      if (cls == 2)
         return 10;
      return (inst == 0) ? 5 : 1;
   endfunction

   function automatic logic [31:0] randInstr();
      int a, b, c;
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      case ($urandom_range(0, 23))
         0:  return rType(a, b, c, 6'h21);
         1:  return iType(6'h09, a, b);
         2:  return iType(6'h23, a, b);
         3:  return iType(6'h24, a, b);
         4:  return iType(6'h2B, a, b);
         5:  return iType(6'h04, a, b);
         6:  return iType(6'h05, a, b);
         7:  return iType(6'h06, a, 0);
         8:  return iType(6'h07, a, 0);
         9:  return iType(6'h01, a, 1);
         10: return rType(a, 0, 0, 6'h08);
         11: return rType(a, 0, c, 6'h09);
         12: return {6'h02, 26'h10};
         13: return {6'h03, 26'h10};
         14: return iType(6'h0F, 0, b);
         15: return rType(a, b, 0, 6'h18);
         16: return rType(a, b, 0, 6'h1B);
         17: return {6'h1C, 5'(a), 5'(b), 10'd0, 6'h04};
         18: return rType(0, 0, c, 6'h10);
         19: return rType(0, 0, c, 6'h12);
         20: return rType(a, 0, 0, 6'h11);
         21: return rType(a, 0, 0, 6'h13);
         22: return 32'd0;
         default: return rType(a, b, c, 6'h00);
      endcase
   endfunction

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      for (int i = 0; i < 2; i++) begin
         int  wE, wM, cnt;
         bit  ha, hb, hc, hd, busy;
         wE   = writeReg(irE);
         wM   = writeReg(irM);
         ha   = isCtrl(irD) && readsReg(irD, wE);
         hb   = (i == 0) && isCtrl(irD) && isLoad(irM) && readsReg(irD, wM);
         hc   = isLoad(irE) && readsReg(irD, wE);
         busy = (cycle < mdEnd[i]) || (mdClass(irE) != 0);
         hd   = busy && isMdUse(irD);
         expStall[i]  = ha || hb || hc || hd;
         expMdOnly[i] = hd && !(ha || hb || hc);
         cnt = (i == 0) ? stallTotal[i] : stallTotal[i] % 16;
         checkEq($sformatf("u%0d pc_en c%0d", i, cycle), 32'(pcEn[i]), 32'(!expStall[i]));
         checkEq($sformatf("u%0d d_en c%0d", i, cycle), 32'(dEn[i]), 32'(!expStall[i]));
         checkEq($sformatf("u%0d e_clr c%0d", i, cycle), 32'(eClr[i]), 32'(expStall[i]));
         checkEq($sformatf("u%0d md_busy c%0d", i, cycle), 32'(mdBusy[i]), 32'(busy));
         checkEq($sformatf("u%0d stall_cnt c%0d", i, cycle), stallObs[i], 32'(cnt));
         cnt = (i == 0) ? mdStallTotal[i] : mdStallTotal[i] % 16;
         checkEq($sformatf("u%0d md_stall_cnt c%0d", i, cycle), mdStallObs[i], 32'(cnt));
      end
   endtask

   // One clock cycle: drive, check mid-cycle, then advance the model across the edge.
   task automatic applyStimulus(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m, input logic rst);
      irD   = d;
      irE   = e;
      irM   = m;
      reset = rst;
      @(negedge clock);
      checkOutput();
      @(posedge clock);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            stallTotal[i]   = 0;
            mdStallTotal[i] = 0;
            mdEnd[i]        = 0;
         end else begin
            if (expStall[i])
               stallTotal[i]++;
            if (expMdOnly[i])
               mdStallTotal[i]++;
            if (cycle >= mdEnd[i] && mdClass(e) != 0)
               mdEnd[i] = cycle + mdLatency(i, mdClass(e));
         end
      end
      cycle++;
      #1;
   endtask

   initial begin
      logic [31:0] lw8, addu10, lw5, jr5, multI, mfloI, divI, mfhiI;
      lw8    = iType(6'h23, 9, 8);
      addu10 = rType(8, 11, 10, 6'h21);
      lw5    = iType(6'h23, 9, 5);
      jr5    = rType(5, 0, 0, 6'h08);
      multI  = rType(1, 2, 0, 6'h18);
      mfloI  = rType(0, 0, 3, 6'h12);
      divI   = rType(1, 2, 0, 6'h1A);
      mfhiI  = rType(0, 0, 3, 6'h10);

      reset = 1'b1;
      irD = '0;
      irE = '0;
      irM = '0;
      repeat (2) @(posedge clock);
      #1;
      cycle = 0;
      for (int i = 0; i < 2; i++) begin
         mdEnd[i] = 0;
         stallTotal[i] = 0;
         mdStallTotal[i] = 0;
      end
      $display("[TB] reset state and load-use stall");
      applyStimulus('0, '0, '0, 1'b0);
      applyStimulus(addu10, lw8, '0, 1'b0);
      checkEq("load-use stall_cnt", stallObs[0], 32'd1);

      $display("[TB] branch against ALU write, $0 ignored");
      applyStimulus(iType(6'h04, 0, 3), rType(1, 2, 0, 6'h21), '0, 1'b0);
      checkEq("beq $0 no stall", stallObs[0], 32'd1);
      applyStimulus(iType(6'h04, 4, 3), rType(1, 2, 4, 6'h21), '0, 1'b0);
      checkEq("beq $4 stall", stallObs[0], 32'd2);

      $display("[TB] mult busy window");
      applyStimulus('0, '0, '0, 1'b1);
      applyStimulus(mfloI, multI, '0, 1'b0);
      repeat (5) applyStimulus(mfloI, '0, '0, 1'b0);
      checkEq("mult md_stall_cnt u0", mdStallObs[0], 32'd5);
      checkEq("mult md_stall_cnt u1", mdStallObs[1], 32'd1);

      $display("[TB] reset aborts div countdown");
      applyStimulus('0, '0, '0, 1'b1);
      applyStimulus(mfhiI, divI, '0, 1'b0);
      repeat (2) applyStimulus(mfhiI, '0, '0, 1'b0);
      applyStimulus(mfhiI, '0, '0, 1'b1);
      checkEq("div abort md_busy", 32'(mdBusy[0]), 32'd0);
      checkEq("div abort pc_en", 32'(pcEn[0]), 32'd1);
      checkEq("div abort stall_cnt", stallObs[0], 32'd0);
      applyStimulus(mfhiI, '0, '0, 1'b0);

      $display("[TB] load in M against jr");
      applyStimulus(jr5, '0, lw5, 1'b0);
      checkEq("jr load-M u0 e_clr", 32'(eClr[0]), 32'd1);
      checkEq("jr load-M u1 e_clr", 32'(eClr[1]), 32'd0);

      $display("[TB] counter wrap");
      applyStimulus('0, '0, '0, 1'b1);
      repeat (17) applyStimulus(addu10, lw8, '0, 1'b0);
      checkEq("wrap stall_cnt u1", stallObs[1], 32'd1);
      checkEq("wrap stall_cnt u0", stallObs[0], 32'd17);

      $display("[TB] randomized traffic");
      repeat (400) applyStimulus(randInstr(), randInstr(), randInstr(), $urandom_range(0, 49) == 0);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
